// File: rtl/osc_pkg.sv
// rtl/osc_pkg.sv - shared sample width, capture state and slope encodings
package osc_pkg;

  localparam int DATA_W = 12;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    WAIT_TRIG,
    POST,
    DONE
  } cap_state_t;

  typedef enum logic {
    SLOPE_RISING  = 1'b0,
    SLOPE_FALLING = 1'b1
  } slope_t;

endpackage

// File: rtl/trigger_capture_if.sv
// rtl/trigger_capture_if.sv - sample stream, trigger setup and readout bundle
interface trigger_capture_if #(
  parameter int DATA_W = osc_pkg::DATA_W,
  parameter int ADDR_W = 8
);
  logic [DATA_W-1:0] sample_in;
  logic              sample_valid;
  logic              signed_mode;
  logic [DATA_W-1:0] trig_level;
  logic              trig_slope;
  logic              arm;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              done;
  logic              auto_trig;

  modport master (
    output sample_in, sample_valid, signed_mode, trig_level, trig_slope, arm, rd_addr,
    input  rd_data, busy, done, auto_trig
  );

  modport slave (
    input  sample_in, sample_valid, signed_mode, trig_level, trig_slope, arm, rd_addr,
    output rd_data, busy, done, auto_trig
  );
endinterface

// File: rtl/capture_ram.sv
// rtl/capture_ram.sv - simple dual-port sample RAM with registered read
module capture_ram #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Only the output register is reset; the array itself keeps its contents.
  always_ff @(posedge clk) begin
    if (rst) rd_data <= '0;
    else     rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/trigger_capture.sv
// rtl/trigger_capture.sv - armed circular capture with level/slope or timeout trigger
module trigger_capture #(
  parameter int DATA_W       = osc_pkg::DATA_W,
  parameter int ADDR_W       = 8,
  parameter int PRETRIG      = 64,
  parameter int AUTO_TIMEOUT = 4096
) (
  input logic         clk,
  input logic         rst,
  trigger_capture_if.slave bus
);
  import osc_pkg::*;

  localparam int DEPTH = 2**ADDR_W;
  localparam int TMO_W = (AUTO_TIMEOUT > 1) ? $clog2(AUTO_TIMEOUT) : 1;
  localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRETRIG - 1);
  localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(DEPTH - PRETRIG - 1);
  localparam logic [ADDR_W-1:0] PRE_OFFS  = ADDR_W'(PRETRIG);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'((AUTO_TIMEOUT > 0) ? AUTO_TIMEOUT - 1 : 0);

  cap_state_t        state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] start_addr;
  logic [TMO_W-1:0]  tmo;
  logic [DATA_W-1:0] prev;
  logic              prev_valid;
  logic              busy_q;
  logic              done_q;
  logic              auto_q;

  logic              capturing;
  logic              wr_en;
  logic              hit;
  logic              forced;
  logic [DATA_W-1:0] prev_key;
  logic [DATA_W-1:0] cur_key;
  logic [DATA_W-1:0] lvl_key;

  // Flipping the sign bit maps two's complement order onto unsigned order.
  always_comb begin
    capturing = (state == PRE) || (state == WAIT_TRIG) || (state == POST);
    wr_en     = capturing && bus.sample_valid && !bus.arm;
    prev_key  = {prev[DATA_W-1] ^ bus.signed_mode, prev[DATA_W-2:0]};
    cur_key   = {bus.sample_in[DATA_W-1] ^ bus.signed_mode, bus.sample_in[DATA_W-2:0]};
    lvl_key   = {bus.trig_level[DATA_W-1] ^ bus.signed_mode, bus.trig_level[DATA_W-2:0]};
    hit       = 1'b0;
    if (bus.trig_slope == SLOPE_FALLING)
      hit = prev_valid && (prev_key > lvl_key) && (cur_key <= lvl_key);
    else
      hit = prev_valid && (prev_key < lvl_key) && (cur_key >= lvl_key);
    forced = (AUTO_TIMEOUT > 0) && (tmo == TMO_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      cnt        <= '0;
      tmo        <= '0;
      start_addr <= '0;
      prev       <= '0;
      prev_valid <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      auto_q     <= 1'b0;
    end else if (bus.arm) begin
      state      <= PRE;
      cnt        <= '0;
      tmo        <= '0;
      prev_valid <= 1'b0;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
    end else if (bus.sample_valid && capturing) begin
      wr_ptr     <= wr_ptr + 1'b1;
      prev       <= bus.sample_in;
      prev_valid <= 1'b1;
      case (state)
        PRE: begin
          if (cnt == PRE_LAST) begin
            state <= WAIT_TRIG;
            cnt   <= '0;
            tmo   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_TRIG: begin
          if (hit || forced) begin
            start_addr <= wr_ptr - PRE_OFFS;
            auto_q     <= !hit;
            if (POST_LAST == '0) begin
              state  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              state <= POST;
              cnt   <= ADDR_W'(1);
            end
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        POST: begin
          if (cnt == POST_LAST) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.auto_trig = auto_q;

  capture_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .we     (wr_en),
    .wr_addr(wr_ptr),
    .wr_data(bus.sample_in),
    .rd_addr(start_addr + bus.rd_addr),
    .rd_data(bus.rd_data)
  );
endmodule

// File: tb/tb_trigger_capture.sv
// tb/tb_trigger_capture.sv - self-checking bench for trigger_capture
module tb_trigger_capture;
  localparam int PRETRIG = 64;
  localparam int AUTO_TO = 100;
  localparam int DEPTH   = 256;
  localparam int POSTN   = DEPTH - PRETRIG;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  trigger_capture_if #(.DATA_W(12), .ADDR_W(8)) bus ();

  trigger_capture #(
    .DATA_W(12),
    .ADDR_W(8),
    .PRETRIG(PRETRIG),
    .AUTO_TIMEOUT(AUTO_TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  logic [11:0] stim[$];
  logic [11:0] exp_rec[DEPTH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int sval(input logic [11:0] v, input logic sm);
    if (sm) return int'($signed(v));
    return int'({20'd0, v});
  endfunction

  // Reference: scan the valid-sample stream after arm for the first qualifying crossing.
  task automatic model(input logic sm, input logic [11:0] lvl, input logic slope,
                       output int tidx, output logic forced);
    tidx   = -1;
    forced = 1'b0;
    for (int i = PRETRIG; i < stim.size(); i++) begin
      int p, c, l;
      p = sval(stim[i-1], sm);
      c = sval(stim[i], sm);
      l = sval(lvl, sm);
      if ((!slope && p < l && c >= l) || (slope && p > l && c <= l)) begin
        tidx = i;
        break;
      end
      if (i - PRETRIG + 1 == AUTO_TO) begin
        tidx   = i;
        forced = 1'b1;
        break;
      end
    end
  endtask

  task automatic play(input string tag, input logic sm, input logic [11:0] lvl,
                      input logic slope, input bit gaps);
    int tidx, idx, cyc;
    logic fx;
    model(sm, lvl, slope, tidx, fx);
    for (int k = 0; k < DEPTH; k++) exp_rec[k] = stim[tidx - PRETRIG + k];
    bus.signed_mode  = sm;
    bus.trig_level   = lvl;
    bus.trig_slope   = slope;
    bus.arm          = 1'b1;
    bus.sample_valid = 1'b1;
    bus.sample_in    = 12'($urandom);
    step();
    bus.arm = 1'b0;
    check({tag, "/busy_after_arm"}, 32'(bus.busy), 32'd1);
    check({tag, "/done_after_arm"}, 32'(bus.done), 32'd0);
    idx = 0;
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 3000) begin
      if (gaps && $urandom_range(0, 1) == 0) begin
        bus.sample_valid = 1'b0;
        bus.sample_in    = 12'($urandom);
      end else begin
        bus.sample_valid = 1'b1;
        bus.sample_in    = (idx < stim.size()) ? stim[idx] : 12'h000;
        idx++;
      end
      step();
      cyc++;
    end
    check({tag, "/sample_count"}, 32'(idx), 32'(tidx + POSTN));
    check({tag, "/done"}, 32'(bus.done), 32'd1);
    check({tag, "/busy"}, 32'(bus.busy), 32'd0);
    check({tag, "/auto_trig"}, 32'(bus.auto_trig), 32'(fx));
    for (int k = 0; k < 8; k++) begin
      bus.sample_valid = 1'b1;
      bus.sample_in    = 12'($urandom);
      step();
    end
    bus.sample_valid = 1'b0;
    check({tag, "/done_hold"}, 32'(bus.done), 32'd1);
    for (int a = 0; a < DEPTH; a++) begin
      bus.rd_addr = 8'(a);
      step();
      check($sformatf("%s/rd%0d", tag, a), 32'(bus.rd_data), 32'(exp_rec[a]));
    end
  endtask

  task automatic read_at(input string tag, input int a, input logic [11:0] exp);
    bus.rd_addr = 8'(a);
    step();
    check(tag, 32'(bus.rd_data), 32'(exp));
  endtask

  initial begin
    bus.sample_in    = '0;
    bus.sample_valid = 1'b0;
    bus.signed_mode  = 1'b0;
    bus.trig_level   = '0;
    bus.trig_slope   = 1'b0;
    bus.arm          = 1'b0;
    bus.rd_addr      = '0;

    rst = 1'b1;
    step();
    step();
    check("rst/busy", 32'(bus.busy), 32'd0);
    check("rst/done", 32'(bus.done), 32'd0);
    check("rst/auto_trig", 32'(bus.auto_trig), 32'd0);
    check("rst/rd_data", 32'(bus.rd_data), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.sample_valid = 1'b1;
      bus.sample_in    = 12'($urandom);
      step();
    end
    bus.sample_valid = 1'b0;
    check("idle/busy", 32'(bus.busy), 32'd0);
    check("idle/done", 32'(bus.done), 32'd0);

    stim.delete();
    for (int i = 0; i < 400; i++) stim.push_back(12'(i * 16));
    play("ramp", 1'b0, 12'h400, 1'b0, 1'b0);
    read_at("ramp/trig_sample", 64, 12'h400);
    read_at("ramp/pre_sample", 63, 12'h3F0);

    // Abort a capture in POST after 250 writes, leaving the write pointer at 250.
    stim.delete();
    for (int i = 0; i < 250; i++) stim.push_back(12'(i * 7 + 5));
    bus.signed_mode = 1'b0;
    bus.trig_level  = 12'h400;
    bus.trig_slope  = 1'b0;
    bus.arm         = 1'b1;
    step();
    bus.arm = 1'b0;
    for (int i = 0; i < 250; i++) begin
      bus.sample_valid = 1'b1;
      bus.sample_in    = stim[i];
      step();
    end
    bus.sample_valid = 1'b0;
    check("abort/busy_in_post", 32'(bus.busy), 32'd1);
    check("abort/done_in_post", 32'(bus.done), 32'd0);
    stim.delete();
    for (int i = 0; i < 400; i++) stim.push_back(12'($urandom));
    play("wrap", 1'b0, 12'h800, 1'b0, 1'b1);

    stim.delete();
    for (int i = 0; i < PRETRIG; i++) stim.push_back(12'h010);
    stim.push_back(12'hFF0);
    while (stim.size() < 400) stim.push_back(12'($urandom_range(1, 12'hFFF)));
    play("sfall", 1'b1, 12'h000, 1'b1, 1'b1);
    read_at("sfall/trig_sample", 64, 12'hFF0);
    play("ufall", 1'b0, 12'h000, 1'b1, 1'b1);

    stim.delete();
    for (int i = 0; i < 400; i++) stim.push_back(12'h123);
    play("auto", 1'b0, 12'h800, 1'b0, 1'b0);

    bus.signed_mode = 1'b0;
    bus.trig_level  = 12'h800;
    bus.trig_slope  = 1'b0;
    bus.arm         = 1'b1;
    step();
    bus.arm = 1'b0;
    for (int i = 0; i < 70; i++) begin
      bus.sample_valid = 1'b1;
      bus.sample_in    = 12'h100;
      step();
    end
    bus.sample_valid = 1'b0;
    check("midrst/busy_before", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst/busy", 32'(bus.busy), 32'd0);
    check("midrst/done", 32'(bus.done), 32'd0);
    bus.sample_valid = 1'b1;
    bus.sample_in    = 12'h900;
    step();
    check("midrst/ignored_busy", 32'(bus.busy), 32'd0);
    for (int i = 0; i < 300; i++) begin
      bus.sample_in = 12'($urandom);
      step();
    end
    bus.sample_valid = 1'b0;
    check("midrst/done_after", 32'(bus.done), 32'd0);

    stim.delete();
    for (int i = 0; i < 400; i++) stim.push_back(12'($urandom));
    play("post_rst", 1'b1, 12'($urandom), 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
